reg_file_sb: RTL and testbench



---
 rtl/rf_pkg.sv | 13 +
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/reg_file_sb.sv | 140 ++++++++++++++
 tb/tb_reg_file_sb.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared types and defaults for the scoreboarded integer register file.
package rf_pkg;

    localparam int XLEN_DEF  = 32;
    localparam int NREGS_DEF = 32;
    localparam int X0_ADDR   = 0;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } rf_state_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending-producer bits: set on issue, cleared on writeback, set wins.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter  int NREGS  = NREGS_DEF,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          run_i,
    input  logic          reg_write_i,
    input  logic [AW-1:0] rd_i,
    input  logic          busy_set_i,
    input  logic [AW-1:0] busy_rd_i,
    input  logic [AW-1:0] rs1_i,
    input  logic [AW-1:0] rs2_i,
    output logic          busy1_o,
    output logic          busy2_o
);

    localparam logic BYP = (BYPASS != 0);

    logic [NREGS-1:0] busy_q;
    logic [NREGS-1:0] busy_d;
    logic             wr_s;
    logic             set_s;
    logic             byp1_s;
    logic             byp2_s;

    assign wr_s  = run_i && reg_write_i && (rd_i != AW'(X0_ADDR));
    assign set_s = run_i && busy_set_i && (busy_rd_i != AW'(X0_ADDR));

    // Next busy vector; a new issue overrides a same-cycle writeback.
    always_comb begin
        busy_d = busy_q;
        for (int i = 0; i < NREGS; i++) begin
            busy_d[i] = (set_s && (busy_rd_i == AW'(i))) ? 1'b1 :
                        (wr_s  && (rd_i      == AW'(i))) ? 1'b0 : busy_q[i];
        end
        busy_d[0] = 1'b0;
    end

    // Busy vector register.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A forwarded writeback hides the stale busy bit unless a new producer is issuing.
    always_comb begin
        byp1_s  = BYP && wr_s && (rd_i == rs1_i) && !(set_s && (busy_rd_i == rs1_i));
        byp2_s  = BYP && wr_s && (rd_i == rs2_i) && !(set_s && (busy_rd_i == rs2_i));
        busy1_o = run_i && busy_q[rs1_i] && !byp1_s;
        busy2_o = run_i && busy_q[rs2_i] && !byp2_s;
    end

endmodule

// File: rtl/reg_file_sb.sv
// Two-read/one-write register file with x0 hardwired, post-reset clear sweep,
// optional write-to-read bypass and a busy scoreboard.
module reg_file_sb
    import rf_pkg::*;
#(
    parameter  int XLEN   = XLEN_DEF,
    parameter  int NREGS  = NREGS_DEF,
    parameter  int BYPASS = 1,
    localparam int AW     = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            reset,
    output logic            ready,
    input  logic            reg_write,
    input  logic [AW-1:0]   rd,
    input  logic [XLEN-1:0] write_data,
    input  logic [AW-1:0]   rs1,
    input  logic [AW-1:0]   rs2,
    output logic [XLEN-1:0] out1,
    output logic [XLEN-1:0] out2,
    input  logic            busy_set,
    input  logic [AW-1:0]   busy_rd,
    output logic            busy1,
    output logic            busy2
);

    localparam logic       BYP      = (BYPASS != 0);
    localparam logic [AW:0] CNT_LAST = (AW+1)'(NREGS - 1);
    localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

    rf_state_t       state_q;
    rf_state_t       state_d;
    logic [AW:0]     cnt_q;
    logic [AW:0]     cnt_d;
    logic            ready_q;
    logic            ready_d;
    logic            run_s;
    logic            mem_we_s;
    logic [AW-1:0]   mem_addr_s;
    logic [XLEN-1:0] mem_wdata_s;
    logic [XLEN-1:0] regs_q [0:NREGS-1];

    assign run_s = (state_q == RUN);
    assign ready = ready_q;

    // Sweep FSM next state and storage write port selection.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ready_d     = ready_q;
        mem_we_s    = 1'b0;
        mem_addr_s  = rd;
        mem_wdata_s = write_data;
        case (state_q)
            INIT: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = cnt_q[AW-1:0];
                mem_wdata_s = {XLEN{1'b0}};
                cnt_d       = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    state_d = RUN;
                    ready_d = 1'b1;
                end else begin
                    state_d = INIT;
                    ready_d = 1'b0;
                end
            end
            RUN: begin
                mem_we_s = reg_write && (rd != AW'(X0_ADDR));
            end
            default: begin
                state_d = INIT;
                cnt_d   = '0;
                ready_d = 1'b0;
            end
        endcase
    end

    // FSM state, sweep counter and ready flag.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= INIT;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Register storage; contents survive the reset edge and are cleared by the sweep.
    always_ff @(posedge clk) begin
        if (reset && mem_we_s) begin
            regs_q[mem_addr_s] <= mem_wdata_s;
        end
    end

    // Read muxes: zero until the sweep finishes and for x0, forwarding when enabled.
    always_comb begin
        out1 = {XLEN{1'b0}};
        out2 = {XLEN{1'b0}};
        if (run_s && (rs1 != AW'(X0_ADDR))) begin
            if (BYP && reg_write && (rd == rs1)) begin
                out1 = write_data;
            end else begin
                out1 = regs_q[rs1];
            end
        end else begin
            out1 = {XLEN{1'b0}};
        end
        if (run_s && (rs2 != AW'(X0_ADDR))) begin
            if (BYP && reg_write && (rd == rs2)) begin
                out2 = write_data;
            end else begin
                out2 = regs_q[rs2];
            end
        end else begin
            out2 = {XLEN{1'b0}};
        end
    end

    rf_scoreboard #(
        .NREGS  (NREGS),
        .BYPASS (BYPASS)
    ) u_scoreboard (
        .clk_i       (clk),
        .rst_ni      (reset),
        .run_i       (run_s),
        .reg_write_i (reg_write),
        .rd_i        (rd),
        .busy_set_i  (busy_set),
        .busy_rd_i   (busy_rd),
        .rs1_i       (rs1),
        .rs2_i       (rs2),
        .busy1_o     (busy1),
        .busy2_o     (busy2)
    );

endmodule

// File: tb/tb_reg_file_sb.sv
// Directed bench: bypass and non-bypass 32x32 files share stimulus; a 16x64 file runs alongside.
module tb_reg_file_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        reg_write;
    logic [4:0]  rd;
    logic [31:0] write_data;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        busy_set;
    logic [4:0]  busy_rd;

    logic        ready_a, busy1_a, busy2_a;
    logic [31:0] out1_a, out2_a;
    logic        ready_b, busy1_b, busy2_b;
    logic [31:0] out1_b, out2_b;

    logic        w_reg_write, w_busy_set;
    logic [3:0]  w_rd, w_rs1, w_rs2, w_busy_rd;
    logic [63:0] w_wd;
    logic        ready_w, busy1_w, busy2_w;
    logic [63:0] out1_w, out2_w;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .ready(ready_a), .reg_write(reg_write), .rd(rd),
        .write_data(write_data), .rs1(rs1), .rs2(rs2), .out1(out1_a), .out2(out2_a),
        .busy_set(busy_set), .busy_rd(busy_rd), .busy1(busy1_a), .busy2(busy2_a));

    reg_file_sb #(.XLEN(32), .NREGS(32), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .ready(ready_b), .reg_write(reg_write), .rd(rd),
        .write_data(write_data), .rs1(rs1), .rs2(rs2), .out1(out1_b), .out2(out2_b),
        .busy_set(busy_set), .busy_rd(busy_rd), .busy1(busy1_b), .busy2(busy2_b));

    reg_file_sb #(.XLEN(64), .NREGS(16), .BYPASS(1)) dut_w (
        .clk(clk), .reset(reset), .ready(ready_w), .reg_write(w_reg_write), .rd(w_rd),
        .write_data(w_wd), .rs1(w_rs1), .rs2(w_rs2), .out1(out1_w), .out2(out2_w),
        .busy_set(w_busy_set), .busy_rd(w_busy_rd), .busy1(busy1_w), .busy2(busy2_w));

    task automatic idle();
        reg_write = 1'b0; rd = 5'd0; write_data = 32'd0; rs1 = 5'd0; rs2 = 5'd0;
        busy_set = 1'b0; busy_rd = 5'd0;
        w_reg_write = 1'b0; w_rd = 4'd0; w_wd = 64'd0; w_rs1 = 4'd0; w_rs2 = 4'd0;
        w_busy_set = 1'b0; w_busy_rd = 4'd0;
    endtask

    // Posedge index (1-based, after release) at which each ready was first seen high; 0 = never.
    task automatic count_ready(output int na, output int nb, output int nw);
        na = 0; nb = 0; nw = 0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (ready_a === 1'b1 && na == 0) na = n;
            if (ready_b === 1'b1 && nb == 0) nb = n;
            if (ready_w === 1'b1 && nw == 0) nw = n;
            if (na != 0 && nb != 0 && nw != 0) break;
        end
    endtask

    task automatic test_reset();
        int na, nb, nw;
        idle();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({ready_a, ready_b, ready_w} !== 3'b000) begin
            errors++; $display("FAIL reset_ready got %b exp 000", {ready_a, ready_b, ready_w});
        end
        @(negedge clk); reset = 1'b1;
        count_ready(na, nb, nw);
        checks++;
        if (na !== 32) begin errors++; $display("FAIL ready_lat_a got %0d exp 32", na); end
        checks++;
        if (nb !== 32) begin errors++; $display("FAIL ready_lat_b got %0d exp 32", nb); end
        checks++;
        if (nw !== 16) begin errors++; $display("FAIL ready_lat_w got %0d exp 16", nw); end
        @(negedge clk);
        for (int i = 1; i < 32; i++) begin
            rs1 = 5'(i); rs2 = 5'(31 - i + 1);
            #1;
            checks++;
            if (out1_a !== 32'd0 || out2_a !== 32'd0 || out1_b !== 32'd0 || busy1_a !== 1'b0) begin
                errors++;
                $display("FAIL swept_zero x%0d got %h %h %h %b exp 0", i, out1_a, out2_a, out1_b, busy1_a);
            end
        end
        for (int i = 1; i < 16; i++) begin
            w_rs1 = 4'(i); w_rs2 = 4'(i);
            #1;
            checks++;
            if (out1_w !== 64'd0 || out2_w !== 64'd0) begin
                errors++; $display("FAIL swept_zero_w x%0d got %h %h exp 0", i, out1_w, out2_w);
            end
        end
    endtask

    task automatic test_bypass();
        @(negedge clk);
        idle();
        reg_write = 1'b1; rd = 5'd5; write_data = 32'hDEAD_BEEF; rs1 = 5'd5; rs2 = 5'd5;
        #2;
        checks++;
        if (out1_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_out1 got %h exp deadbeef", out1_a); end
        checks++;
        if (out2_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL bypass_out2 got %h exp deadbeef", out2_a); end
        checks++;
        if (out1_b !== 32'd0) begin errors++; $display("FAIL nobypass_out1 got %h exp 0", out1_b); end
        @(negedge clk);
        reg_write = 1'b0;
        #2;
        checks++;
        if (out1_a !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_a got %h exp deadbeef", out1_a); end
        checks++;
        if (out1_b !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stored_b got %h exp deadbeef", out1_b); end
    endtask

    task automatic test_x0();
        @(negedge clk);
        idle();
        reg_write = 1'b1; rd = 5'd0; write_data = 32'h1234_5678;
        busy_set = 1'b1; busy_rd = 5'd0;
        #2;
        checks++;
        if (out1_a !== 32'd0 || out2_a !== 32'd0 || out1_b !== 32'd0) begin
            errors++; $display("FAIL x0_bypass got %h %h %h exp 0", out1_a, out2_a, out1_b);
        end
        @(negedge clk);
        idle();
        #2;
        checks++;
        if (out1_a !== 32'd0 || out2_b !== 32'd0) begin
            errors++; $display("FAIL x0_stored got %h %h exp 0", out1_a, out2_b);
        end
        checks++;
        if (busy1_a !== 1'b0 || busy2_a !== 1'b0) begin
            errors++; $display("FAIL x0_busy got %b%b exp 00", busy1_a, busy2_a);
        end
    endtask

    task automatic test_scoreboard();
        @(negedge clk);
        idle();
        busy_set = 1'b1; busy_rd = 5'd7; rs1 = 5'd7; rs2 = 5'd7;
        #2;
        checks++;
        if (busy1_a !== 1'b0) begin errors++; $display("FAIL busy_before_edge got %b exp 0", busy1_a); end
        @(negedge clk);
        busy_set = 1'b0;
        #2;
        checks++;
        if (busy1_a !== 1'b1 || busy2_b !== 1'b1) begin
            errors++; $display("FAIL busy_set got %b%b exp 11", busy1_a, busy2_b);
        end
        @(negedge clk);
        reg_write = 1'b1; rd = 5'd7; write_data = 32'h0000_0777;
        #2;
        checks++;
        if (busy1_a !== 1'b0) begin errors++; $display("FAIL busy_bypass_clr got %b exp 0", busy1_a); end
        checks++;
        if (busy1_b !== 1'b1) begin errors++; $display("FAIL busy_nobypass got %b exp 1", busy1_b); end
        checks++;
        if (out1_a !== 32'h0000_0777) begin errors++; $display("FAIL wb_bypass got %h exp 777", out1_a); end
        @(negedge clk);
        reg_write = 1'b0;
        #2;
        checks++;
        if (busy1_b !== 1'b0 || busy2_a !== 1'b0) begin
            errors++; $display("FAIL busy_cleared got %b%b exp 00", busy1_b, busy2_a);
        end
        @(negedge clk);
        busy_set = 1'b1; busy_rd = 5'd7; reg_write = 1'b1; rd = 5'd7; write_data = 32'h0000_0888;
        #2;
        checks++;
        if (busy1_a !== 1'b0) begin errors++; $display("FAIL set_clr_pre got %b exp 0", busy1_a); end
        @(negedge clk);
        #2;
        checks++;
        if (busy1_a !== 1'b1) begin errors++; $display("FAIL set_wins_comb got %b exp 1", busy1_a); end
        checks++;
        if (out1_a !== 32'h0000_0888) begin errors++; $display("FAIL set_clr_data got %h exp 888", out1_a); end
        @(negedge clk);
        idle();
        rs1 = 5'd7;
        #2;
        checks++;
        if (busy1_a !== 1'b1 || busy1_b !== 1'b1) begin
            errors++; $display("FAIL set_wins_reg got %b%b exp 11", busy1_a, busy1_b);
        end
        checks++;
        if (out1_b !== 32'h0000_0888) begin errors++; $display("FAIL set_clr_stored got %h exp 888", out1_b); end
    endtask

    task automatic test_reset_mid();
        int na, nb, nw;
        @(negedge clk);
        idle();
        reg_write = 1'b1; rd = 5'd3; write_data = 32'd9; busy_set = 1'b1; busy_rd = 5'd3;
        @(negedge clk);
        idle();
        rs1 = 5'd3;
        #2;
        checks++;
        if (out1_a !== 32'd9 || busy1_a !== 1'b1) begin
            errors++; $display("FAIL x3_setup got %h %b exp 9 1", out1_a, busy1_a);
        end
        @(negedge clk); reset = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ready_a !== 1'b0 || busy1_a !== 1'b0) begin
            errors++; $display("FAIL run_reset got %b %b exp 0 0", ready_a, busy1_a);
        end
        @(negedge clk); reset = 1'b1;
        repeat (10) @(posedge clk);
        @(negedge clk); reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        reg_write = 1'b1; rd = 5'd3; write_data = 32'h0000_00AA;
        busy_set = 1'b1; busy_rd = 5'd3; rs1 = 5'd3; rs2 = 5'd3;
        #2;
        checks++;
        if (out1_a !== 32'd0 || busy1_a !== 1'b0) begin
            errors++; $display("FAIL init_gated got %h %b exp 0 0", out1_a, busy1_a);
        end
        count_ready(na, nb, nw);
        checks++;
        if (na !== 32 || nb !== 32) begin
            errors++; $display("FAIL restart_lat got %0d %0d exp 32 32", na, nb);
        end
        checks++;
        if (nw !== 16) begin errors++; $display("FAIL restart_lat_w got %0d exp 16", nw); end
        @(negedge clk);
        idle();
        rs1 = 5'd3; rs2 = 5'd3;
        #2;
        checks++;
        if (out1_a !== 32'd0 || out2_b !== 32'd0) begin
            errors++; $display("FAIL x3_swept got %h %h exp 0", out1_a, out2_b);
        end
        checks++;
        if (busy1_a !== 1'b0 || busy2_b !== 1'b0) begin
            errors++; $display("FAIL x3_busy_after got %b%b exp 00", busy1_a, busy2_b);
        end
    endtask

    task automatic test_wide();
        @(negedge clk);
        idle();
        w_reg_write = 1'b1; w_rd = 4'd15; w_wd = 64'hFFFF_FFFF_FFFF_FFFF;
        w_rs1 = 4'd15; w_rs2 = 4'd15;
        #2;
        checks++;
        if (out1_w !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL wide_bypass got %h exp all ones", out1_w);
        end
        @(negedge clk);
        w_reg_write = 1'b0;
        #2;
        checks++;
        if (out1_w !== 64'hFFFF_FFFF_FFFF_FFFF || out2_w !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            errors++; $display("FAIL wide_stored got %h %h exp all ones", out1_w, out2_w);
        end
        w_rs1 = 4'd14;
        #1;
        checks++;
        if (out1_w !== 64'd0 || busy1_w !== 1'b0 || busy2_w !== 1'b0) begin
            errors++; $display("FAIL wide_neighbour got %h %b%b exp 0 00", out1_w, busy1_w, busy2_w);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_x0();
        test_scoreboard();
        test_reset_mid();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
